// File: rtl/bram_dp_be.sv
// True dual-port block RAM with per-byte write enables, 1- or 2-cycle read latency and
// port-0-priority byte arbitration. Define BRAM_COLLISION_DETECT_EN for a sticky collision flag.
module bram_dp_be #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DEPTH        = 1 << ADDR_WIDTH,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RDW_MODE     = 0,
    parameter string       INIT_FILE    = ""
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    en0_i,
    input  logic [DATA_WIDTH/8-1:0] we0_i,
    input  logic [ADDR_WIDTH-1:0]   address0_i,
    input  logic [DATA_WIDTH-1:0]   data_in0_i,
    output logic [DATA_WIDTH-1:0]   data_out0_o,
    output logic                    valid0_o,
    input  logic                    en1_i,
    input  logic [DATA_WIDTH/8-1:0] we1_i,
    input  logic [ADDR_WIDTH-1:0]   address1_i,
    input  logic [DATA_WIDTH-1:0]   data_in1_i,
    output logic [DATA_WIDTH-1:0]   data_out1_o,
    output logic                    valid1_o,
    output logic                    collision_o
);
    localparam int NB    = int'(DATA_WIDTH / 8);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      idx0, idx1;
    logic                  in0, in1, wr0, wr1;
    logic [DATA_WIDTH-1:0] old0, old1, rd0_d, rd1_d;

    logic [DATA_WIDTH-1:0] s1_data0_q, s1_data1_q;
    logic                  s1_valid0_q, s1_valid1_q;

    assign in0  = 32'(address0_i) < DEPTH;
    assign in1  = 32'(address1_i) < DEPTH;
    assign idx0 = address0_i[IDX_W-1:0];
    assign idx1 = address1_i[IDX_W-1:0];
    assign wr0  = en0_i && in0 && (|we0_i);
    assign wr1  = en1_i && in1 && (|we1_i);
    assign old0 = in0 ? mem[idx0] : '0;
    assign old1 = in1 ? mem[idx1] : '0;

    // Same-port new-data mode merges only this port's bytes; the other port always sees old data.
    always_comb begin
        rd0_d = old0;
        rd1_d = old1;
        if (RDW_MODE == 1) begin
            for (int i = 0; i < NB; i++) begin
                if (in0 && we0_i[i]) rd0_d[8*i +: 8] = data_in0_i[8*i +: 8];
                if (in1 && we1_i[i]) rd1_d[8*i +: 8] = data_in1_i[8*i +: 8];
            end
        end
    end

    // Reset only blocks writes here; array contents survive it. Port 0 is written last so it wins.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NB; i++) begin
                if (wr1 && we1_i[i]) mem[idx1][8*i +: 8] <= data_in1_i[8*i +: 8];
            end
            for (int i = 0; i < NB; i++) begin
                if (wr0 && we0_i[i]) mem[idx0][8*i +: 8] <= data_in0_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            s1_data0_q  <= '0;
            s1_data1_q  <= '0;
            s1_valid0_q <= 1'b0;
            s1_valid1_q <= 1'b0;
        end else begin
            s1_valid0_q <= en0_i;
            s1_valid1_q <= en1_i;
            if (en0_i) s1_data0_q <= rd0_d;
            if (en1_i) s1_data1_q <= rd1_d;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_data0_q, s2_data1_q;
            logic                  s2_valid0_q, s2_valid1_q;

            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    s2_data0_q  <= '0;
                    s2_data1_q  <= '0;
                    s2_valid0_q <= 1'b0;
                    s2_valid1_q <= 1'b0;
                end else begin
                    s2_valid0_q <= s1_valid0_q;
                    s2_valid1_q <= s1_valid1_q;
                    if (s1_valid0_q) s2_data0_q <= s1_data0_q;
                    if (s1_valid1_q) s2_data1_q <= s1_data1_q;
                end
            end

            assign data_out0_o = s2_data0_q;
            assign data_out1_o = s2_data1_q;
            assign valid0_o    = s2_valid0_q;
            assign valid1_o    = s2_valid1_q;
        end else begin : g_lat1
            assign data_out0_o = s1_data0_q;
            assign data_out1_o = s1_data1_q;
            assign valid0_o    = s1_valid0_q;
            assign valid1_o    = s1_valid1_q;
        end
    endgenerate

`ifdef BRAM_COLLISION_DETECT_EN
    logic collision_q;
    logic coll_hit;

    assign coll_hit = wr0 && wr1 && (address0_i == address1_i) && (|(we0_i & we1_i));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            collision_q <= 1'b0;
        end else if (coll_hit) begin
            collision_q <= 1'b1;
            $display("bram_dp_be: write collision at address 0x%0h", address0_i);
        end
    end

    assign collision_o = collision_q;
`else
    assign collision_o = 1'b0;
`endif

endmodule

// File: tb/tb_bram_dp_be.sv
// Bench for bram_dp_be: three instances (lat1/old-data, lat2/new-data, lat1 with DEPTH=6)
// share one stimulus stream and are checked against a word-level memory model every cycle.
module tb_bram_dp_be;
    localparam int unsigned AW   = 4;
    localparam int          NDUT = 3;
    localparam int unsigned LAT [NDUT] = '{1, 2, 1};
    localparam int unsigned RDW [NDUT] = '{0, 1, 0};
    localparam int unsigned DEP [NDUT] = '{16, 16, 6};
`ifdef BRAM_COLLISION_DETECT_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          en   [2];
    logic [3:0]    we   [2];
    logic [AW-1:0] addr [2];
    logic [31:0]   din  [2];
    logic [31:0]   dout [NDUT][2];
    logic          vld  [NDUT][2];
    logic          coll [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bram_dp_be #(
            .DATA_WIDTH  (32),
            .ADDR_WIDTH  (AW),
            .DEPTH       (DEP[g]),
            .READ_LATENCY(LAT[g]),
            .RDW_MODE    (RDW[g]),
            .INIT_FILE   ("")
        ) u_dut (
            .clock_i    (clk),
            .reset_i    (rst),
            .en0_i      (en[0]),
            .we0_i      (we[0]),
            .address0_i (addr[0]),
            .data_in0_i (din[0]),
            .data_out0_o(dout[g][0]),
            .valid0_o   (vld[g][0]),
            .en1_i      (en[1]),
            .we1_i      (we[1]),
            .address1_i (addr[1]),
            .data_in1_i (din[1]),
            .data_out1_o(dout[g][1]),
            .valid1_o   (vld[g][1]),
            .collision_o(coll[g])
        );
    end

    int n_pass;
    int n_total;
    bit chk_on;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Model state: memory image with a "contents known" flag, last-cycle read per port,
    // and the expected outputs.
    logic [31:0] m_mem   [NDUT][16];
    bit          m_known [NDUT][16];
    bit          m_coll  [NDUT];
    bit          h_v [NDUT][2];
    logic [31:0] h_d [NDUT][2];
    bit          h_k [NDUT][2];
    bit          e_v [NDUT][2];
    logic [31:0] e_d [NDUT][2];
    bit          e_k [NDUT][2];

    task automatic model_step();
        bit          nv [2];
        logic [31:0] nd [2];
        bit          nk [2];
        bit          ov, okn;
        logic [31:0] od;
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                m_coll[k] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    h_v[k][p] = 1'b0;
                    e_v[k][p] = 1'b0;
                    e_d[k][p] = '0;
                    e_k[k][p] = 1'b1;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    nv[p] = en[p];
                    nd[p] = '0;
                    nk[p] = 1'b1;
                    if (addr[p] < DEP[k]) begin
                        nd[p] = m_mem[k][addr[p]];
                        nk[p] = m_known[k][addr[p]];
                        if (RDW[k] == 1 && en[p]) begin
                            for (int b = 0; b < 4; b++)
                                if (we[p][b]) nd[p][8*b +: 8] = din[p][8*b +: 8];
                        end
                    end
                end
                // Bytes enabled on port 0 take port 0 data; otherwise port 1 data.
                for (int q = 1; q >= 0; q--) begin
                    if (en[q] && addr[q] < DEP[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (we[q][b]) m_mem[k][addr[q]][8*b +: 8] = din[q][8*b +: 8];
                        if (we[q] == 4'hF) m_known[k][addr[q]] = 1'b1;
                    end
                end
                if (en[0] && en[1] && addr[0] == addr[1] && addr[0] < DEP[k]
                    && (we[0] & we[1]) != 4'h0) m_coll[k] = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    if (LAT[k] == 1) begin
                        ov = nv[p]; od = nd[p]; okn = nk[p];
                    end else begin
                        ov = h_v[k][p]; od = h_d[k][p]; okn = h_k[k][p];
                    end
                    h_v[k][p] = nv[p];
                    h_d[k][p] = nd[p];
                    h_k[k][p] = nk[p];
                    e_v[k][p] = ov;
                    if (ov) begin
                        e_d[k][p] = od;
                        e_k[k][p] = okn;
                    end
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            m_coll[k] = 1'b0;
            for (int a = 0; a < 16; a++) begin
                m_mem[k][a]   = '0;
                m_known[k][a] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                h_v[k][p] = 1'b0; h_d[k][p] = '0; h_k[k][p] = 1'b1;
                e_v[k][p] = 1'b0; e_d[k][p] = '0; e_k[k][p] = 1'b1;
            end
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int k = 0; k < NDUT; k++) begin
                    for (int p = 0; p < 2; p++) begin
                        check($sformatf("dut%0d.valid%0d", k, p), 32'(vld[k][p]),
                              rst ? 32'd0 : 32'(e_v[k][p]));
                        if (rst || e_k[k][p])
                            check($sformatf("dut%0d.data_out%0d", k, p), dout[k][p],
                                  rst ? 32'd0 : e_d[k][p]);
                    end
                    check($sformatf("dut%0d.collision", k), 32'(coll[k]),
                          (rst || !COLL_EN) ? 32'd0 : 32'(m_coll[k]));
                end
            end
        end
    end

    task automatic cyc(input bit r,
                       input bit e0, input logic [3:0] w0, input int a0, input logic [31:0] d0,
                       input bit e1, input logic [3:0] w1, input int a1, input logic [31:0] d1);
        rst     = r;
        en[0]   = e0; we[0] = w0; addr[0] = AW'(a0); din[0] = d0;
        en[1]   = e1; we[1] = w1; addr[1] = AW'(a1); din[1] = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 4'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0);
    endtask

    int cnt, first, last, cnt_pre, cnt_post;

    initial begin
        n_pass = 0;
        n_total = 0;
        chk_on = 1'b0;
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            en[p] = 1'b0; we[p] = '0; addr[p] = '0; din[p] = '0;
        end
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        repeat (2) cyc(1, 0, 4'h0, 0, 32'h0, 0, 4'h0, 0, 32'h0);

        // Bring every word to a known zero.
        for (int i = 0; i < 8; i++) cyc(0, 1, 4'hF, 2*i, 32'h0, 1, 4'hF, 2*i+1, 32'h0);
        idle();

        // Test 1: requests under reset are ignored.
        cyc(1, 1, 4'hF, 5, 32'h12345678, 1, 4'hF, 7, 32'h9);
        check("t1 valid0 in reset", 32'(vld[0][0]), 32'd0);
        check("t1 data_out0 in reset", dout[0][0], 32'h0);
        cyc(1, 1, 4'hF, 5, 32'h12345678, 1, 4'hF, 7, 32'h9);
        cyc(0, 1, 4'h0, 5, 32'h0, 1, 4'h0, 7, 32'h0);
        check("t1 valid0 after reset", 32'(vld[0][0]), 32'd1);
        check("t1 addr5 unchanged", dout[0][0], 32'h0);
        check("t1 addr7 unchanged", dout[0][1], 32'h0);
        idle();

        // Test 2: byte-enabled writes.
        cyc(0, 1, 4'hF, 5, 32'hAABBCCDD, 0, 4'h0, 0, 32'h0);
        cyc(0, 1, 4'b0101, 5, 32'h11223344, 0, 4'h0, 0, 32'h0);
        cyc(0, 1, 4'h0, 5, 32'h0, 0, 4'h0, 0, 32'h0);
        check("t2 lat1 data", dout[0][0], 32'hAA22CC44);
        check("t2 lat1 valid", 32'(vld[0][0]), 32'd1);
        check("t2 depth6 data", dout[2][0], 32'hAA22CC44);
        idle();
        check("t2 lat1 valid pulse ends", 32'(vld[0][0]), 32'd0);
        check("t2 lat2 data", dout[1][0], 32'hAA22CC44);
        check("t2 lat2 valid", 32'(vld[1][0]), 32'd1);

        // Test 3: read-during-write, same port and cross port.
        cyc(0, 1, 4'hF, 7, 32'hDEADBEEF, 1, 4'h0, 7, 32'h0);
        check("t3 rdw0 port0 old", dout[0][0], 32'h0);
        check("t3 rdw0 port1 old", dout[0][1], 32'h0);
        idle();
        check("t3 rdw1 port0 new", dout[1][0], 32'hDEADBEEF);
        check("t3 rdw1 port1 old", dout[1][1], 32'h0);

        // Test 4: both ports write address 3.
        cyc(0, 1, 4'b0001, 3, 32'h000000FF, 1, 4'hF, 3, 32'hFFFFFF00);
        cyc(0, 1, 4'h0, 3, 32'h0, 0, 4'h0, 0, 32'h0);
        check("t4 merged word", dout[0][0], 32'hFFFFFFFF);
        check("t4 collision", 32'(coll[0]), 32'(COLL_EN));
        idle();

        // Test 5: back-to-back reads, then reset on the 4th request cycle.
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) cyc(0, 1, 4'h0, i, 32'h0, 1, 4'h0, i, 32'h0);
            else idle();
            if (vld[1][0]) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            if (i == 4) check("t5 lat2 addr3", dout[1][0], 32'hFFFFFFFF);
            if (i == 6) check("t5 lat2 addr5", dout[1][1], 32'hAA22CC44);
        end
        check("t5 valid count", 32'(cnt), 32'd8);
        check("t5 first valid", 32'(first), 32'd1);
        check("t5 last valid", 32'(last), 32'd8);
        cnt_pre = 0; cnt_post = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) cyc(i >= 3, 1, 4'h0, i, 32'h0, 1, 4'h0, i, 32'h0);
            else idle();
            if (i < 3) cnt_pre += int'(vld[1][0]);
            else cnt_post += int'(vld[1][0]) + int'(vld[1][1]);
        end
        check("t5 valids before reset", 32'(cnt_pre), 32'd2);
        check("t5 valids after reset", 32'(cnt_post), 32'd0);

        // Test 6: out-of-range access on the DEPTH=6 instance.
        cyc(0, 1, 4'hF, 6, 32'hCAFEF00D, 0, 4'h0, 0, 32'h0);
        cyc(0, 1, 4'h0, 6, 32'h0, 0, 4'h0, 0, 32'h0);
        check("t6 oor data", dout[2][0], 32'h0);
        check("t6 oor valid", 32'(vld[2][0]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 4'h0, i, 32'h0, 0, 4'h0, 0, 32'h0);
            if (i == 5) check("t6 addr5 intact", dout[2][0], 32'hAA22CC44);
            if (i == 3) check("t6 addr3 intact", dout[2][0], 32'hFFFFFFFF);
        end
        repeat (3) idle();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
